complex_dot_product_row_feeder: RTL and testbench

- Producer for the complex 8-wide dot-product multiply/control unit. Fetches two complex rows from dual read-only row memories and packs them into no_of_units-element packages.
- Presents each package with a one-cycle read-now strobe, then waits for the consumer's finish and captures the final dot product.
- Sits between the row buffers and the dot-product engine. Acts as the initiator end of the read_now/finish exchange.

---
 rtl/complex_dot_product_row_feeder.sv | 188 ++++++++++++++++++
 tb/tb_complex_dot_product_row_feeder.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/complex_dot_product_row_feeder.sv
// Row feeder for the complex dot-product engine. It fetches rows A and B,
// packs them into no_of_units-element packages and pulses read-now for each.
// Ports:
//   clk_i, reset_i          clock, synchronous active-high reset
//   start_i, total_i        job request and element count
//   a_base_i, b_base_i      row start addresses
//   mem_rd_en_o, a/b_addr_o row-memory read port (1-cycle latency)
//   a/b_rdata_i             row-memory read data
//   first/second_row_input_o packages to the consumer
//   outsider_read_now_o     package strobe
//   dp_reset_o              consumer clear pulse
//   total_out_o             latched total for the consumer
//   finish_i, dot_product_output_i consumer handshake and result
//   result_o, done_o, busy_o, error_o status
module complex_dot_product_row_feeder #(
   parameter int element_width  = 64,
   parameter int no_of_units    = 8,
   parameter int addr_width     = 10,
   parameter int timeout_cycles = 1024
) (
   input  logic                                 clk_i,
   input  logic                                 reset_i,
   input  logic                                 start_i,
   input  logic [31:0]                          total_i,
   input  logic [addr_width-1:0]                a_base_i,
   input  logic [addr_width-1:0]                b_base_i,
   output logic                                 mem_rd_en_o,
   output logic [addr_width-1:0]                a_addr_o,
   output logic [addr_width-1:0]                b_addr_o,
   input  logic [element_width-1:0]             a_rdata_i,
   input  logic [element_width-1:0]             b_rdata_i,
   output logic [element_width*no_of_units-1:0] first_row_input_o,
   output logic [element_width*no_of_units-1:0] second_row_input_o,
   output logic                                 outsider_read_now_o,
   output logic                                 dp_reset_o,
   output logic [31:0]                          total_out_o,
   input  logic                                 finish_i,
   input  logic [element_width-1:0]             dot_product_output_i,
   output logic [element_width-1:0]             result_o,
   output logic                                 done_o,
   output logic                                 busy_o,
   output logic                                 error_o
);

   localparam int PW = element_width * no_of_units;
   localparam int CW = $clog2(no_of_units + 1);
   localparam logic [CW-1:0] LAST = CW'(no_of_units);
   localparam logic [31:0] TO_LAST = 32'(timeout_cycles - 1);

   typedef enum logic [2:0] {
      IDLE, CLEAR, FILL, ISSUE, WAIT_FINISH
   } state_e;

   state_e state_q, state_d;

   logic [addr_width-1:0] a_addr_q, b_addr_q;
   logic [CW-1:0]         fill_cnt_q;
   logic [31:0]           pkg_left_q;
   logic [31:0]           wait_cnt_q;
   logic [31:0]           total_q;
   logic [PW-1:0]         asm_a_q, asm_b_q;
   logic [PW-1:0]         asm_a_d, asm_b_d;
   logic [PW-1:0]         pkg_a_q, pkg_b_q;
   logic [element_width-1:0] result_q;
   logic                  done_q, error_q;
   logic                  total_ok, rd_en, finish_hit, timeout_hit;

   assign total_ok = (total_i != 32'd0) &&
                     (total_i % 32'(no_of_units) == 32'd0);
   assign finish_hit  = finish_i;
   assign timeout_hit = (wait_cnt_q == TO_LAST);

   // Shift left so the first element read ends up in the MSB slot.
   assign asm_a_d = {asm_a_q[PW-element_width-1:0], a_rdata_i};
   assign asm_b_d = {asm_b_q[PW-element_width-1:0], b_rdata_i};

   always_ff @(posedge clk_i) begin
      if (reset_i) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:        if (start_i && total_ok) state_d = CLEAR;
         CLEAR:       state_d = FILL;
         FILL:        if (fill_cnt_q == LAST) state_d = ISSUE;
         ISSUE:       state_d = (pkg_left_q == 32'd1) ? WAIT_FINISH : FILL;
         WAIT_FINISH: if (finish_hit || timeout_hit) state_d = IDLE;
         default:     state_d = IDLE;
      endcase
   end

   always_comb begin
      rd_en               = 1'b0;
      dp_reset_o          = 1'b0;
      outsider_read_now_o = 1'b0;
      busy_o              = (state_q != IDLE);
      unique case (state_q)
         CLEAR:   dp_reset_o = 1'b1;
         FILL:    rd_en = (fill_cnt_q != LAST);
         ISSUE:   outsider_read_now_o = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         a_addr_q   <= '0;
         b_addr_q   <= '0;
         fill_cnt_q <= '0;
         pkg_left_q <= '0;
         wait_cnt_q <= '0;
         total_q    <= '0;
         asm_a_q    <= '0;
         asm_b_q    <= '0;
         pkg_a_q    <= '0;
         pkg_b_q    <= '0;
         result_q   <= '0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            IDLE: if (start_i) begin
               if (!total_ok) begin
                  error_q <= 1'b1;
                  done_q  <= 1'b1;
               end else begin
                  error_q    <= 1'b0;
                  total_q    <= total_i;
                  a_addr_q   <= a_base_i;
                  b_addr_q   <= b_base_i;
                  pkg_left_q <= total_i / 32'(no_of_units);
                  fill_cnt_q <= '0;
               end
            end
            FILL: begin
               if (rd_en) begin
                  a_addr_q <= a_addr_q + addr_width'(1);
                  b_addr_q <= b_addr_q + addr_width'(1);
               end
               // Data lags the read by one cycle, so slot k lands at count k+1.
               if (fill_cnt_q != '0) begin
                  asm_a_q <= asm_a_d;
                  asm_b_q <= asm_b_d;
               end
               // Load the packages on the edge into ISSUE so they are
               // already valid while read-now is high.
               if (fill_cnt_q == LAST) begin
                  fill_cnt_q <= '0;
                  pkg_a_q    <= asm_a_d;
                  pkg_b_q    <= asm_b_d;
               end else begin
                  fill_cnt_q <= fill_cnt_q + CW'(1);
               end
            end
            ISSUE: begin
               pkg_left_q <= pkg_left_q - 32'd1;
               wait_cnt_q <= '0;
            end
            WAIT_FINISH: begin
               if (finish_hit) begin
                  result_q <= dot_product_output_i;
                  done_q   <= 1'b1;
               end else if (timeout_hit) begin
                  error_q <= 1'b1;
                  done_q  <= 1'b1;
               end else begin
                  wait_cnt_q <= wait_cnt_q + 32'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign mem_rd_en_o        = rd_en;
   assign a_addr_o           = a_addr_q;
   assign b_addr_o           = b_addr_q;
   assign first_row_input_o  = pkg_a_q;
   assign second_row_input_o = pkg_b_q;
   assign total_out_o        = total_q;
   assign result_o           = result_q;
   assign done_o             = done_q;
   assign error_o            = error_q;

endmodule

// File: tb/tb_complex_dot_product_row_feeder.sv
// Directed/randomized bench for complex_dot_product_row_feeder.
// Models memories and consumer; checks against a row-level reference.
module tb_complex_dot_product_row_feeder;

   localparam int EW = 64;
   localparam int N  = 8;
   localparam int AW = 10;
   localparam int TO = 32;
   localparam int PW = EW * N;
   localparam int MS = 1 << AW;

   logic          clk = 1'b0;
   logic          reset_i = 1'b1;
   logic          start_i = 1'b0;
   logic [31:0]   total_i = '0;
   logic [AW-1:0] a_base_i = '0, b_base_i = '0;
   logic          mem_rd_en_o;
   logic [AW-1:0] a_addr_o, b_addr_o;
   logic [EW-1:0] a_rdata_i = '0, b_rdata_i = '0;
   logic [PW-1:0] first_row_input_o, second_row_input_o;
   logic          outsider_read_now_o, dp_reset_o;
   logic [31:0]   total_out_o;
   logic          finish_i = 1'b0;
   logic [EW-1:0] dot_product_output_i = '0;
   logic [EW-1:0] result_o;
   logic          done_o, busy_o, error_o;

   complex_dot_product_row_feeder #(
      .element_width(EW), .no_of_units(N),
      .addr_width(AW), .timeout_cycles(TO)
   ) dut (
      .clk_i(clk), .reset_i(reset_i), .start_i(start_i),
      .total_i(total_i), .a_base_i(a_base_i), .b_base_i(b_base_i),
      .mem_rd_en_o(mem_rd_en_o), .a_addr_o(a_addr_o),
      .b_addr_o(b_addr_o), .a_rdata_i(a_rdata_i),
      .b_rdata_i(b_rdata_i),
      .first_row_input_o(first_row_input_o),
      .second_row_input_o(second_row_input_o),
      .outsider_read_now_o(outsider_read_now_o),
      .dp_reset_o(dp_reset_o), .total_out_o(total_out_o),
      .finish_i(finish_i),
      .dot_product_output_i(dot_product_output_i),
      .result_o(result_o), .done_o(done_o), .busy_o(busy_o),
      .error_o(error_o)
   );

   always #5 clk = ~clk;

   logic [EW-1:0] mem_a [MS];
   logic [EW-1:0] mem_b [MS];

   always @(posedge clk) begin
      if (mem_rd_en_o) begin
         a_rdata_i <= mem_a[a_addr_o];
         b_rdata_i <= mem_b[b_addr_o];
      end
   end

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int rd_cnt, dpr_cnt, dpr_cyc, done_cnt, done_cyc, pkg_changes;
   logic err_at_done;
   int addr_a_q[$], addr_b_q[$], strobe_cyc[$];
   logic [PW-1:0] pkg_a_q[$], pkg_b_q[$];
   logic [PW-1:0] prev_a = '0, prev_b = '0;
   logic [EW-1:0] m_result = '0;

   task automatic chk(string tag, logic [PW-1:0] obs,
                      logic [PW-1:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clr_mon();
      rd_cnt = 0; dpr_cnt = 0; dpr_cyc = -1;
      done_cnt = 0; done_cyc = -1; pkg_changes = 0;
      err_at_done = 1'b0;
      addr_a_q.delete(); addr_b_q.delete(); strobe_cyc.delete();
      pkg_a_q.delete(); pkg_b_q.delete();
   endtask

   // One cycle: sample DUT at the falling edge and act as the consumer.
   task automatic tick();
      @(negedge clk);
      cyc++;
      if (mem_rd_en_o) begin
         rd_cnt++;
         addr_a_q.push_back(int'(a_addr_o));
         addr_b_q.push_back(int'(b_addr_o));
      end
      if (dp_reset_o) begin
         dpr_cnt++; dpr_cyc = cyc; finish_i = 1'b0;
      end
      if (outsider_read_now_o) begin
         strobe_cyc.push_back(cyc);
         pkg_a_q.push_back(first_row_input_o);
         pkg_b_q.push_back(second_row_input_o);
      end
      if (done_o) begin
         done_cnt++; done_cyc = cyc; err_at_done = error_o;
      end
      if ((first_row_input_o !== prev_a ||
           second_row_input_o !== prev_b) &&
          !outsider_read_now_o && !reset_i)
         pkg_changes++;
      prev_a = first_row_input_o;
      prev_b = second_row_input_o;
   endtask

   function automatic logic [PW-1:0] exp_pkg(int base, int p, bit isb);
      logic [PW-1:0] r;
      r = '0;
      for (int k = 0; k < N; k++) begin
         int idx;
         idx = (base + p * N + k) % MS;
         r[EW*(N-k)-1 -: EW] = isb ? mem_b[idx] : mem_a[idx];
      end
      return r;
   endfunction

   // fd < 0: consumer never finishes. bs >= 0: extra start while busy.
   task automatic run_op(string nm, int tot, int ab, int bb, int fd,
                         logic [EW-1:0] dpv, int bs);
      int s, P, budget, L, bad_a, bad_b;
      bit ok;
      ok = (tot != 0) && (tot % N == 0);
      P = ok ? tot / N : 0;
      clr_mon();
      total_i = 32'(tot);
      a_base_i = AW'(ab);
      b_base_i = AW'(bb);
      start_i = 1'b1;
      s = cyc;
      tick();
      start_i = 1'b0;
      budget = 3000;
      while (done_cnt == 0 && budget > 0) begin
         if (fd >= 0 && P > 0 && strobe_cyc.size() == P &&
             cyc == strobe_cyc[P-1] + fd) begin
            finish_i = 1'b1;
            dot_product_output_i = dpv;
         end
         start_i = (bs >= 0 && cyc == s + bs);
         if (start_i) total_i = 32'd16;
         tick();
         budget--;
      end
      start_i = 1'b0;
      for (int i = 0; i < 12; i++) tick();
      chk({nm, "_done_cnt"}, done_cnt, 1);
      chk({nm, "_busy_end"}, busy_o, 1'b0);
      if (!ok) begin
         chk({nm, "_done_cyc"}, done_cyc, s + 1);
         chk({nm, "_err"}, err_at_done, 1'b1);
         chk({nm, "_rd_cnt"}, rd_cnt, 0);
         chk({nm, "_dpr_cnt"}, dpr_cnt, 0);
         chk({nm, "_result"}, result_o, m_result);
         return;
      end
      chk({nm, "_dpr_cnt"}, dpr_cnt, 1);
      chk({nm, "_dpr_cyc"}, dpr_cyc, s + 1);
      chk({nm, "_total_out"}, total_out_o, tot);
      chk({nm, "_rd_cnt"}, rd_cnt, tot);
      bad_a = 0; bad_b = 0;
      for (int i = 0; i < addr_a_q.size() && i < tot; i++) begin
         if (addr_a_q[i] != (ab + i) % MS) bad_a++;
         if (addr_b_q[i] != (bb + i) % MS) bad_b++;
      end
      chk({nm, "_addr_a_bad"}, bad_a, 0);
      chk({nm, "_addr_b_bad"}, bad_b, 0);
      chk({nm, "_strobes"}, strobe_cyc.size(), P);
      for (int p = 0; p < P && p < strobe_cyc.size(); p++) begin
         chk($sformatf("%s_strobe%0d_cyc", nm, p), strobe_cyc[p],
             s + N + 3 + p * (N + 2));
         chk($sformatf("%s_pkg_a%0d", nm, p), pkg_a_q[p],
             exp_pkg(ab, p, 1'b0));
         chk($sformatf("%s_pkg_b%0d", nm, p), pkg_b_q[p],
             exp_pkg(bb, p, 1'b1));
      end
      chk({nm, "_pkg_stable"}, pkg_changes, 0);
      L = s + N + 3 + (P - 1) * (N + 2);
      if (fd >= 0) begin
         m_result = dpv;
         chk({nm, "_done_cyc"}, done_cyc, L + fd + 1);
         chk({nm, "_err"}, err_at_done, 1'b0);
      end else begin
         chk({nm, "_done_cyc"}, done_cyc, L + 1 + TO);
         chk({nm, "_err"}, err_at_done, 1'b1);
      end
      chk({nm, "_result"}, result_o, m_result);
   endtask

   task automatic chk_zero(string nm);
      chk({nm, "_busy"}, busy_o, 1'b0);
      chk({nm, "_done"}, done_o, 1'b0);
      chk({nm, "_error"}, error_o, 1'b0);
      chk({nm, "_result"}, result_o, 0);
      chk({nm, "_total_out"}, total_out_o, 0);
      chk({nm, "_pkg_a"}, first_row_input_o, 0);
      chk({nm, "_pkg_b"}, second_row_input_o, 0);
      chk({nm, "_rd_en"}, mem_rd_en_o, 1'b0);
      chk({nm, "_addr"}, {a_addr_o, b_addr_o}, 0);
      chk({nm, "_strobes"}, {outsider_read_now_o, dp_reset_o}, 0);
   endtask

   initial begin
      int budget;
      logic [PW-1:0] pk;
      for (int i = 0; i < MS; i++) begin
         mem_a[i] = {$urandom, $urandom};
         mem_b[i] = {$urandom, $urandom};
      end
      for (int i = 0; i < N; i++) begin
         mem_a[i] = {32'(i + 1), 32'h0};
         mem_b[i] = {32'(i + 1), 32'h0};
      end
      clr_mon();
      repeat (3) tick();
      chk_zero("rst");
      reset_i = 1'b0;
      tick();

      run_op("t8", 8, 0, 0, 20, 64'hCC, -1);
      pk = pkg_a_q.size() > 0 ? pkg_a_q[0] : '0;
      chk("t8_msb_slot", pk[PW-1 -: EW], {32'd1, 32'd0});
      chk("t8_lsb_slot", pk[EW-1:0], {32'd8, 32'd0});

      run_op("t32", 32, 100, 300, 5, {$urandom, $urandom}, -1);
      run_op("bad12", 12, 7, 9, 3, 64'h1, -1);
      run_op("bad0", 0, 7, 9, 3, 64'h1, -1);
      run_op("tmo", 8, 40, 50, -1, 64'h0, -1);

      clr_mon();
      total_i = 32'd32;
      a_base_i = AW'(200);
      b_base_i = AW'(210);
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      budget = 200;
      while (strobe_cyc.size() < 1 && budget > 0) begin
         tick();
         budget--;
      end
      chk("mid_first_strobe", strobe_cyc.size(), 1);
      repeat (3) tick();
      chk("mid_in_fill", mem_rd_en_o, 1'b1);
      reset_i = 1'b1;
      tick();
      m_result = '0;
      chk_zero("mid");
      reset_i = 1'b0;
      tick();
      run_op("post", 16, 500, 600, 7, {$urandom, $urandom}, -1);

      run_op("wrap", 8, MS - 4, MS - 5, 3, {$urandom, $urandom}, 5);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog no_finish observed=stuck expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
